// File: rtl/pong_renderer_if.sv
// Pixel stream, live game state and rendered output of the pong renderer.
// The master drives pixels and game state; the slave (renderer) returns colour.
interface pong_renderer_if #(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned SCORE_W = 7
);
    logic               pix_valid;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               frame_start;
    logic [COORD_W-1:0] ball_x;
    logic [COORD_W-1:0] ball_y;
    logic [COORD_W-1:0] paddleL_y;
    logic [COORD_W-1:0] paddleR_y;
    logic [SCORE_W-1:0] scoreL;
    logic [SCORE_W-1:0] scoreR;
    logic               game_over;
    logic               left_win;
    logic               right_win;
    logic               out_valid;
    logic [23:0]        out_color;

    modport master (
        output pix_valid, x, y, frame_start, ball_x, ball_y, paddleL_y, paddleR_y,
               scoreL, scoreR, game_over, left_win, right_win,
        input  out_valid, out_color
    );

    modport slave (
        input  pix_valid, x, y, frame_start, ball_x, ball_y, paddleL_y, paddleR_y,
               scoreL, scoreR, game_over, left_win, right_win,
        output out_valid, out_color
    );
endinterface

// File: rtl/pong_renderer_pipe.sv
// Pong frame renderer: per-frame snapshot of game state feeding a two-stage pixel
// pipeline (hit tests, then colour resolve) with a fixed 2-cycle latency.
module pong_renderer_pipe #(
    parameter int unsigned COORD_W      = 10,
    parameter int unsigned SCORE_W      = 7,
    parameter int unsigned DIGIT_SCALE  = 4,
    parameter int unsigned BALL_SIZE    = 10,
    parameter int unsigned PADDLE_W     = 10,
    parameter int unsigned PADDLE_H     = 60,
    parameter int unsigned PADDLEL_X    = 3,
    parameter int unsigned PADDLER_X    = 630,
    parameter int unsigned MIDLINE_X    = 320,
    parameter int unsigned MIDLINE_W    = 4,
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned FLASH_FRAMES = 30
) (
    input logic            clk,
    input logic            rst,
    pong_renderer_if.slave bus
);
    localparam int unsigned EW       = COORD_W + 1;
    localparam int unsigned CNT_W    = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam int unsigned DIG_W    = 3 * DIGIT_SCALE;
    localparam int unsigned DIG_H    = 5 * DIGIT_SCALE;
    localparam int unsigned DIG_TOP  = 10;
    localparam int unsigned L_TENS_X = SCREEN_W / 4 - (7 * DIGIT_SCALE) / 2;
    localparam int unsigned R_TENS_X = 3 * SCREEN_W / 4 - (7 * DIGIT_SCALE) / 2;
    localparam int unsigned UNIT_OFS = 4 * DIGIT_SCALE;

    // One extra bit so obj + size never wraps at the right/bottom edge.
    typedef logic [EW-1:0] ext_t;

    typedef struct packed {
        logic [COORD_W-1:0] ball_x;
        logic [COORD_W-1:0] ball_y;
        logic [COORD_W-1:0] paddle_l_y;
        logic [COORD_W-1:0] paddle_r_y;
        logic [SCORE_W-1:0] score_l;
        logic [SCORE_W-1:0] score_r;
        logic               game_over;
        logic               left_win;
        logic               right_win;
    } snap_t;

    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               ball;
        logic               pad_l;
        logic               pad_r;
        logic               mid;
        logic               score;
        logic [3:0]         digit;
        logic [1:0]         col;
        logic [2:0]         row;
        logic               game_over;
        logic               left_win;
        logic               right_win;
        logic               flash;
    } s1_t;

    function automatic logic in_span(ext_t v, ext_t lo, ext_t len);
        return (v >= lo) && (v < lo + len);
    endfunction

    function automatic logic [6:0] sat99(logic [SCORE_W-1:0] s);
        return (int'(s) > 99) ? 7'd99 : 7'(s);
    endfunction

    // 3x5 glyphs, row 0 in the top three bits, leftmost column as MSB of each row.
    function automatic logic glyph_bit(logic [3:0] d, logic [2:0] row, logic [1:0] col);
        logic [14:0] g;
        case (d)
            4'd0:    g = 15'b111_101_101_101_111;
            4'd1:    g = 15'b010_110_010_010_111;
            4'd2:    g = 15'b111_001_111_100_111;
            4'd3:    g = 15'b111_001_111_001_111;
            4'd4:    g = 15'b101_101_111_001_001;
            4'd5:    g = 15'b111_100_111_001_111;
            4'd6:    g = 15'b111_100_111_101_111;
            4'd7:    g = 15'b111_001_001_001_001;
            4'd8:    g = 15'b111_101_111_101_111;
            4'd9:    g = 15'b111_101_111_001_111;
            default: g = '0;
        endcase
        return g[4'(14 - 3 * int'(row) - int'(col))];
    endfunction

    snap_t             snap_q, snap_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              flash_q, flash_d;
    s1_t               s1_q, s1_d;
    logic              out_valid_q, out_valid_d;
    logic [23:0]       out_color_q, out_color_d;

    always_comb begin
        snap_d      = snap_q;
        frame_cnt_d = frame_cnt_q;
        flash_d     = flash_q;
        if (bus.frame_start) begin
            snap_d.ball_x     = bus.ball_x;
            snap_d.ball_y     = bus.ball_y;
            snap_d.paddle_l_y = bus.paddleL_y;
            snap_d.paddle_r_y = bus.paddleR_y;
            snap_d.score_l    = bus.scoreL;
            snap_d.score_r    = bus.scoreR;
            snap_d.game_over  = bus.game_over;
            snap_d.left_win   = bus.left_win;
            snap_d.right_win  = bus.right_win;
            // Flash counting follows the snapshot of the frame that is ending.
            if (!snap_q.game_over) begin
                frame_cnt_d = '0;
                flash_d     = 1'b0;
            end else if (frame_cnt_q == CNT_W'(FLASH_FRAMES - 1)) begin
                frame_cnt_d = '0;
                flash_d     = ~flash_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    ext_t       xe, ye, box_x0;
    logic [6:0] sat_l, sat_r;
    logic [3:0] tens_l, units_l, tens_r, units_r;
    logic       show, in_box;

    always_comb begin
        xe      = ext_t'(bus.x);
        ye      = ext_t'(bus.y);
        sat_l   = sat99(snap_q.score_l);
        sat_r   = sat99(snap_q.score_r);
        tens_l  = 4'(sat_l / 7'd10);
        units_l = 4'(sat_l % 7'd10);
        tens_r  = 4'(sat_r / 7'd10);
        units_r = 4'(sat_r % 7'd10);
        box_x0  = '0;
        show    = 1'b0;
        in_box  = 1'b1;
        s1_d    = '0;
        if (in_span(xe, ext_t'(L_TENS_X), ext_t'(DIG_W))) begin
            box_x0     = ext_t'(L_TENS_X);
            s1_d.digit = tens_l;
            show       = (tens_l != 4'd0);
        end else if (in_span(xe, ext_t'(L_TENS_X + UNIT_OFS), ext_t'(DIG_W))) begin
            box_x0     = ext_t'(L_TENS_X + UNIT_OFS);
            s1_d.digit = units_l;
            show       = 1'b1;
        end else if (in_span(xe, ext_t'(R_TENS_X), ext_t'(DIG_W))) begin
            box_x0     = ext_t'(R_TENS_X);
            s1_d.digit = tens_r;
            show       = (tens_r != 4'd0);
        end else if (in_span(xe, ext_t'(R_TENS_X + UNIT_OFS), ext_t'(DIG_W))) begin
            box_x0     = ext_t'(R_TENS_X + UNIT_OFS);
            s1_d.digit = units_r;
            show       = 1'b1;
        end else begin
            in_box     = 1'b0;
        end
        s1_d.valid     = bus.pix_valid;
        s1_d.x         = bus.x;
        s1_d.y         = bus.y;
        s1_d.ball      = in_span(xe, ext_t'(snap_q.ball_x), ext_t'(BALL_SIZE)) &&
                         in_span(ye, ext_t'(snap_q.ball_y), ext_t'(BALL_SIZE));
        s1_d.pad_l     = in_span(xe, ext_t'(PADDLEL_X), ext_t'(PADDLE_W)) &&
                         in_span(ye, ext_t'(snap_q.paddle_l_y), ext_t'(PADDLE_H));
        s1_d.pad_r     = in_span(xe, ext_t'(PADDLER_X), ext_t'(PADDLE_W)) &&
                         in_span(ye, ext_t'(snap_q.paddle_r_y), ext_t'(PADDLE_H));
        s1_d.mid       = in_span(xe, ext_t'(MIDLINE_X - MIDLINE_W / 2), ext_t'(MIDLINE_W)) &&
                         !bus.y[4];
        s1_d.score     = in_box && show && in_span(ye, ext_t'(DIG_TOP), ext_t'(DIG_H));
        s1_d.col       = 2'((xe - box_x0) / ext_t'(DIGIT_SCALE));
        s1_d.row       = 3'((ye - ext_t'(DIG_TOP)) / ext_t'(DIGIT_SCALE));
        s1_d.game_over = snap_q.game_over;
        s1_d.left_win  = snap_q.left_win;
        s1_d.right_win = snap_q.right_win;
        s1_d.flash     = flash_q;
    end

    logic        lit, offscreen;
    logic [23:0] win_bg, pix_color;

    always_comb begin
        lit       = s1_q.score && glyph_bit(s1_q.digit, s1_q.row, s1_q.col);
        offscreen = (ext_t'(s1_q.x) >= ext_t'(SCREEN_W)) || (ext_t'(s1_q.y) >= ext_t'(SCREEN_H));
        if (s1_q.left_win) begin
            win_bg = 24'h00FF00;
        end else if (s1_q.right_win) begin
            win_bg = 24'hFF0000;
        end else begin
            win_bg = 24'h000000;
        end
        if (offscreen) begin
            pix_color = 24'h000000;
        end else if (s1_q.game_over) begin
            if (s1_q.flash) begin
                pix_color = lit ? 24'hFFFFFF : 24'h000000;
            end else begin
                pix_color = lit ? 24'h000000 : win_bg;
            end
        end else if (s1_q.ball || s1_q.pad_l || s1_q.pad_r || lit || s1_q.mid) begin
            pix_color = 24'h000000;
        end else begin
            pix_color = 24'hFFFFFF;
        end
        out_valid_d = s1_q.valid;
        out_color_d = s1_q.valid ? pix_color : out_color_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q      <= '0;
            frame_cnt_q <= '0;
            flash_q     <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_color_q <= '0;
        end else begin
            snap_q      <= snap_d;
            frame_cnt_q <= frame_cnt_d;
            flash_q     <= flash_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            out_color_q <= out_color_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_color = out_color_q;
endmodule
